blt_update_arb: RTL and testbench

Write-side controller for the branch lookup table. Arbitrates branch-resolution updates from two requesters, the branch compare unit and the jump-register unit, onto the table's single write port. It buffers them in a small in-order queue so the execute stage never stalls on a port conflict. It sits between the execute stage and the table's `write`/`write_key`/`write_val`/`hit` inputs.

---
 rtl/blt_update_arb_pkg.sv | 47 ++++
 rtl/blt_update_fifo.sv | 84 ++++++++
 rtl/blt_update_arb.sv | 125 ++++++++++++
 tb/tb_blt_update_arb.sv | 232 +++++++++++++++++++++++
 4 files changed

// File: rtl/blt_update_arb_pkg.sv
`default_nettype none
// ============================================================================
// Module      : blt_update_arb_pkg
// Description : Shared types, defaults and helpers for the branch lookup
//               table write-side arbiter. Also provides fallback values for
//               the shared macros ADDR_WIDTH, BLT_ARB_DEPTH and
//               BLT_ARB_COUNT_WIDTH when defines.vh has not set them.
// Revision    : 1.0 - initial release
// ============================================================================

`ifndef ADDR_WIDTH
`define ADDR_WIDTH 32
`endif

`ifndef BLT_ARB_DEPTH
`define BLT_ARB_DEPTH 4
`endif

`ifndef BLT_ARB_COUNT_WIDTH
`define BLT_ARB_COUNT_WIDTH 3
`endif

package blt_update_arb_pkg;

  localparam int DEFAULT_DEPTH = `BLT_ARB_DEPTH;
  localparam int DEFAULT_AW    = `ADDR_WIDTH;

  // Round-robin pointer value names the side that wins a tie.
  typedef enum logic {
    SIDE_BRANCH = 1'b0,
    SIDE_JR     = 1'b1
  } side_e;

  // One-hot grant {jr, branch}: a lone requester always wins, a tie goes to
  // the side the pointer names.
  function automatic logic [1:0] rr_grant(input logic [1:0] valid, input side_e ptr);
    logic [1:0] g;
    g = valid;
    if (valid == 2'b11) begin
      g = (ptr == SIDE_BRANCH) ? 2'b01 : 2'b10;
    end
    return g;
  endfunction

endpackage

`default_nettype wire

// File: rtl/blt_update_fifo.sv
`default_nettype none
// ============================================================================
// Module      : blt_update_fifo
// Description : DEPTH x W circular buffer holding pending table updates.
//               Push/pop may occur together; clear empties it on the next
//               edge. Head entry is presented combinationally on dout.
// Revision    : 1.0 - initial release
// ============================================================================

module blt_update_fifo #(
  parameter int DEPTH = 4,
  parameter int W     = 1
) (
  input  logic                         clk,
  input  logic                         reset,
  input  logic                         push,
  input  logic                         pop,
  input  logic                         clear,
  input  logic [W-1:0]                 din,
  output logic [W-1:0]                 dout,
  output logic [$clog2(DEPTH+1)-1:0]   count
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = $clog2(DEPTH+1);

  logic [W-1:0]  mem_q [DEPTH];
  logic [W-1:0]  mem_d [DEPTH];
  logic [PW-1:0] wr_ptr_q, wr_ptr_d;
  logic [PW-1:0] rd_ptr_q, rd_ptr_d;
  logic [CW-1:0] count_q,  count_d;

  // Next-state for storage, pointers and occupancy; pointers wrap naturally
  // because DEPTH is a power of two.
  always_comb begin
    mem_d    = mem_q;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (clear) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      count_d  = '0;
    end else begin
      if (push) begin
        mem_d[wr_ptr_q] = din;
        wr_ptr_d        = wr_ptr_q + PW'(1);
      end
      if (pop) begin
        rd_ptr_d = rd_ptr_q + PW'(1);
      end
      case ({push, pop})
        2'b10:   count_d = count_q + CW'(1);
        2'b01:   count_d = count_q - CW'(1);
        default: count_d = count_q;
      endcase
    end
  end

  // State register with asynchronous active-low clear of everything.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      for (int i = 0; i < DEPTH; i++) begin
        mem_q[i] <= '0;
      end
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      for (int i = 0; i < DEPTH; i++) begin
        mem_q[i] <= mem_d[i];
      end
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  assign dout  = mem_q[rd_ptr_q];
  assign count = count_q;

endmodule

`default_nettype wire

// File: rtl/blt_update_arb.sv
`default_nettype none
// ============================================================================
// Module      : blt_update_arb
// Description : Round-robin arbiter that merges branch-unit and jr-unit
//               resolution updates into an in-order queue draining onto the
//               branch lookup table's single write port.
//               Optional build macro BLT_ARB_BYPASS_EN: when the queue is
//               empty and the port is free, the granted request is written
//               in the same cycle instead of being enqueued.
// Revision    : 1.0 - initial release
// ============================================================================

module blt_update_arb
  import blt_update_arb_pkg::*;
#(
  parameter int DEPTH = DEFAULT_DEPTH,
  parameter int AW    = DEFAULT_AW
) (
  input  logic                         clk,
  input  logic                         reset,
  input  logic                         req0_valid,
  input  logic [AW-1:0]                req0_key,
  input  logic [AW-1:0]                req0_val,
  input  logic                         req0_hit,
  output logic                         req0_ready,
  input  logic                         req1_valid,
  input  logic [AW-1:0]                req1_key,
  input  logic [AW-1:0]                req1_val,
  input  logic                         req1_hit,
  output logic                         req1_ready,
  input  logic                         stall,
  input  logic                         flush,
  output logic                         blt_write,
  output logic [AW-1:0]                blt_write_key,
  output logic [AW-1:0]                blt_write_val,
  output logic                         blt_hit,
  output logic [$clog2(DEPTH+1)-1:0]   count
);

  localparam int CW = $clog2(DEPTH+1);
  localparam int EW = 2*AW + 1;

  side_e         ptr_q, ptr_d;
  logic [1:0]    grant;
  logic [CW-1:0] fifo_count;
  logic [EW-1:0] head_entry;
  logic [EW-1:0] req_entry;
  logic [EW-1:0] out_entry;
  logic          drain;
  logic          space;
  logic          accept0, accept1, accept_any;
  logic          bypass_fire;
  logic          push;

  // Grant, space and handshake; readys are forced low while reset is held.
  always_comb begin
    grant      = rr_grant({req1_valid, req0_valid}, ptr_q);
    drain      = (fifo_count != '0) & ~stall & ~flush;
    space      = (fifo_count < CW'(DEPTH)) | drain;
    req0_ready = grant[0] & space & ~flush & reset;
    req1_ready = grant[1] & space & ~flush & reset;
    accept0    = req0_valid & req0_ready;
    accept1    = req1_valid & req1_ready;
    accept_any = accept0 | accept1;
    req_entry  = accept1 ? {req1_key, req1_val, req1_hit}
                         : {req0_key, req0_val, req0_hit};
  end

  // Pointer moves to the non-granted side only when a transfer happens.
  always_comb begin
    ptr_d = ptr_q;
    if (accept0) begin
      ptr_d = SIDE_JR;
    end else if (accept1) begin
      ptr_d = SIDE_BRANCH;
    end
  end

  // Round-robin pointer register.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      ptr_q <= SIDE_BRANCH;
    end else begin
      ptr_q <= ptr_d;
    end
  end

  // Decide between queueing and same-cycle forwarding, then select the
  // table write payload (zero whenever no write is presented).
  always_comb begin
`ifdef BLT_ARB_BYPASS_EN
    bypass_fire = accept_any & (fifo_count == '0) & ~stall & ~flush;
`else
    bypass_fire = 1'b0;
`endif
    push      = accept_any & ~bypass_fire;
    blt_write = drain | bypass_fire;
    out_entry = '0;
    if (drain) begin
      out_entry = head_entry;
    end else if (bypass_fire) begin
      out_entry = req_entry;
    end
    {blt_write_key, blt_write_val, blt_hit} = out_entry;
  end

  blt_update_fifo #(
    .DEPTH (DEPTH),
    .W     (EW)
  ) u_fifo (
    .clk   (clk),
    .reset (reset),
    .push  (push),
    .pop   (drain),
    .clear (flush),
    .din   (req_entry),
    .dout  (head_entry),
    .count (fifo_count)
  );

  assign count = fifo_count;

endmodule

`default_nettype wire

// File: tb/tb_blt_update_arb.sv
`default_nettype none
// ============================================================================
// Module      : tb_blt_update_arb
// Description : Self-checking bench for blt_update_arb. A queue-based model
//               predicts readys, write strobes and occupancy; a monitor pops
//               expected table writes whenever the DUT writes.
// Revision    : 1.0 - initial release
// ============================================================================

module tb_blt_update_arb;

  localparam int DEPTH = 4;
  localparam int AW    = 16;
`ifdef BLT_ARB_BYPASS_EN
  localparam bit BYP = 1'b1;
`else
  localparam bit BYP = 1'b0;
`endif

  typedef struct packed {
    logic [AW-1:0] key;
    logic [AW-1:0] val;
    logic          hit;
  } ent_t;

  logic          clk = 1'b0;
  logic          reset;
  logic          req0_valid, req1_valid;
  logic [AW-1:0] req0_key, req0_val, req1_key, req1_val;
  logic          req0_hit, req1_hit;
  logic          req0_ready, req1_ready;
  logic          stall, flush;
  logic          blt_write;
  logic [AW-1:0] blt_write_key, blt_write_val;
  logic          blt_hit;
  logic [2:0]    count;

  int   checks = 0;
  int   errors = 0;
  ent_t exp_q[$];
  bit   rr = 1'b0;

  blt_update_arb #(.DEPTH(DEPTH), .AW(AW)) dut (
    .clk           (clk),
    .reset         (reset),
    .req0_valid    (req0_valid),
    .req0_key      (req0_key),
    .req0_val      (req0_val),
    .req0_hit      (req0_hit),
    .req0_ready    (req0_ready),
    .req1_valid    (req1_valid),
    .req1_key      (req1_key),
    .req1_val      (req1_val),
    .req1_hit      (req1_hit),
    .req1_ready    (req1_ready),
    .stall         (stall),
    .flush         (flush),
    .blt_write     (blt_write),
    .blt_write_key (blt_write_key),
    .blt_write_val (blt_write_val),
    .blt_hit       (blt_hit),
    .count         (count)
  );

  always #5 clk = ~clk;

  function automatic void chk(input string nm, input longint act, input longint exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", nm, act, exp, $time);
    end
  endfunction

  // One cycle: drive inputs, predict from the queue model, check, update model.
  task automatic step(input logic v0, input logic [AW-1:0] k0, input logic [AW-1:0] d0,
                      input logic h0, input logic v1, input logic [AW-1:0] k1,
                      input logic [AW-1:0] d1, input logic h1, input logic st,
                      input logic fl, output logic a0, output logic a1);
    int sz;
    bit drn, spc, g0, g1, ew;
    @(posedge clk);
    #1;
    req0_valid = v0; req0_key = k0; req0_val = d0; req0_hit = h0;
    req1_valid = v1; req1_key = k1; req1_val = d1; req1_hit = h1;
    stall = st; flush = fl;
    sz  = exp_q.size();
    drn = (sz > 0) && !st && !fl;
    spc = (sz < DEPTH) || drn;
    if (v0 && v1) begin
      g0 = (rr == 1'b0);
      g1 = (rr == 1'b1);
    end else begin
      g0 = v0;
      g1 = v1;
    end
    a0 = g0 && spc && !fl;
    a1 = g1 && spc && !fl;
    ew = drn || (BYP && (sz == 0) && !st && !fl && (a0 || a1));
    #1;
    chk("count", longint'(count), longint'(sz));
    chk("req0_ready", longint'(req0_ready), longint'(a0));
    chk("req1_ready", longint'(req1_ready), longint'(a1));
    chk("blt_write", longint'(blt_write), longint'(ew));
    if (a0) begin
      exp_q.push_back('{key: k0, val: d0, hit: h0});
      rr = 1'b1;
    end else if (a1) begin
      exp_q.push_back('{key: k1, val: d1, hit: h1});
      rr = 1'b0;
    end
    if (fl) exp_q.delete();
  endtask

  task automatic idle(input int n);
    logic a0, a1;
    for (int i = 0; i < n; i++) step(0, '0, '0, 0, 0, '0, '0, 0, 0, 0, a0, a1);
  endtask

  // Monitor: every presented table write must match the oldest expected one.
  initial begin
    ent_t e;
    forever begin
      @(negedge clk);
      if (reset && blt_write) begin
        checks++;
        if (exp_q.size() == 0) begin
          errors++;
          $display("FAIL unexpected_write: got key 0x%0h, expected no write at %0t", blt_write_key, $time);
        end else begin
          e = exp_q.pop_front();
          checks--;
          chk("write_key", longint'(blt_write_key), longint'(e.key));
          chk("write_val", longint'(blt_write_val), longint'(e.val));
          chk("write_hit", longint'(blt_hit), longint'(e.hit));
        end
      end
    end
  end

  initial begin
    logic a0, a1;
    int idx;
    logic pv0, pv1, ph0, ph1;
    logic [AW-1:0] pk0, pd0, pk1, pd1;

    reset = 1'b0;
    req0_valid = 1'b1; req0_key = 16'h1; req0_val = 16'h2; req0_hit = 1'b1;
    req1_valid = 1'b1; req1_key = '0; req1_val = '0; req1_hit = 1'b0;
    stall = 1'b0; flush = 1'b0;
    #12;
    chk("rst_ready0", longint'(req0_ready), 0);
    chk("rst_ready1", longint'(req1_ready), 0);
    chk("rst_write", longint'(blt_write), 0);
    chk("rst_count", longint'(count), 0);
    chk("rst_key", longint'(blt_write_key), 0);
    chk("rst_val", longint'(blt_write_val), 0);
    chk("rst_hit", longint'(blt_hit), 0);
    @(posedge clk); #1;
    reset = 1'b1; req0_valid = 1'b0; req1_valid = 1'b0;

    // Single branch-unit update.
    step(1, 16'h100, 16'h200, 1, 0, '0, '0, 0, 0, 0, a0, a1);
    idle(3);

    // Both requesters contending: grants alternate 0,1,0,1.
    step(1, 16'h10, 16'h11, 1, 1, 16'h20, 16'h21, 0, 0, 0, a0, a1);
    step(1, 16'h30, 16'h31, 0, 1, 16'h20, 16'h21, 0, 0, 0, a0, a1);
    step(1, 16'h30, 16'h31, 0, 1, 16'h40, 16'h41, 1, 0, 0, a0, a1);
    step(1, 16'h50, 16'h51, 1, 1, 16'h40, 16'h41, 1, 0, 0, a0, a1);
    idle(4);

    // Stall with back-to-back branch updates, then release into full+drain.
    idx = 0;
    for (int i = 0; i < 6; i++) begin
      step(1, 16'h300 + AW'(idx), 16'h400 + AW'(idx), idx[0], 0, '0, '0, 0, 1, 0, a0, a1);
      if (a0) idx++;
    end
    for (int i = 0; i < 6 && idx < 8; i++) begin
      step(1, 16'h300 + AW'(idx), 16'h400 + AW'(idx), idx[0], 0, '0, '0, 0, 0, 0, a0, a1);
      if (a0) idx++;
    end
    idle(6);

    // Three queued, then flush with both requesting; nothing stale after.
    for (int i = 0; i < 3; i++)
      step(0, '0, '0, 0, 1, 16'h700 + AW'(i), 16'h800 + AW'(i), 1, 1, 0, a0, a1);
    step(1, 16'h9, 16'h9, 1, 1, 16'h7ff, 16'h8ff, 0, 1, 1, a0, a1);
    idle(4);

    // Asynchronous reset while two entries are draining.
    step(1, 16'h501, 16'h601, 1, 0, '0, '0, 0, 1, 0, a0, a1);
    step(1, 16'h502, 16'h602, 0, 0, '0, '0, 0, 1, 0, a0, a1);
    step(0, '0, '0, 0, 0, '0, '0, 0, 0, 0, a0, a1);
    #1;
    reset = 1'b0;
    #1;
    chk("async_rst_write", longint'(blt_write), 0);
    chk("async_rst_count", longint'(count), 0);
    exp_q.delete();
    rr = 1'b0;
    @(posedge clk); #1;
    req0_valid = 1'b1;
    #1;
    chk("in_rst_ready0", longint'(req0_ready), 0);
    reset = 1'b1;
    req0_valid = 1'b0;

    // Randomized traffic with payloads held until accepted.
    pv0 = 0; pv1 = 0; pk0 = '0; pd0 = '0; pk1 = '0; pd1 = '0; ph0 = 0; ph1 = 0;
    for (int i = 0; i < 500; i++) begin
      if (!pv0 && $urandom_range(0, 99) < 60) begin
        pv0 = 1; pk0 = AW'($urandom); pd0 = AW'($urandom); ph0 = 1'($urandom);
      end
      if (!pv1 && $urandom_range(0, 99) < 60) begin
        pv1 = 1; pk1 = AW'($urandom); pd1 = AW'($urandom); ph1 = 1'($urandom);
      end
      step(pv0, pk0, pd0, ph0, pv1, pk1, pd1, ph1,
           1'($urandom_range(0, 99) < 30), 1'($urandom_range(0, 99) < 4), a0, a1);
      if (a0) pv0 = 0;
      if (a1) pv1 = 0;
    end
    idle(DEPTH + 3);
    chk("final_empty", longint'(exp_q.size()), 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

`default_nettype wire
